// File: rtl/vpu_pkg.sv
// vpu_pkg: shared types and constants for the VPU issue stage.
//   fields_t          - decoded instruction fields (opcode in the LSBs)
//   inst_t            - full 64-bit instruction word (2 reserved MSBs + fields)
//   vpu_issue_state_t - issue FSM state encoding
//   mk_inst           - helper that assembles an instruction word
package vpu_pkg;

    localparam int INST_W   = 64;
    localparam int ADDR_W   = 13;
    localparam int OP_W     = 10;
    localparam int FIELDS_W = OP_W + 4 * ADDR_W;

    localparam logic [OP_W-1:0] OPC_HALT = '0;

    // Packed structs list MSB first: cnst sits at [61:49], opcode at [9:0].
    typedef struct packed {
        logic [ADDR_W-1:0] cnst;
        logic [ADDR_W-1:0] c;
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] a;
        logic [OP_W-1:0]   opcode;
    } fields_t;

    typedef struct packed {
        logic [1:0] rsvd;
        fields_t    f;
    } inst_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_MEM,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT_VPU,
        ST_FINISH
    } vpu_issue_state_t;

    function automatic inst_t mk_inst(input logic [OP_W-1:0]   op,
                                      input logic [ADDR_W-1:0] a,
                                      input logic [ADDR_W-1:0] b,
                                      input logic [ADDR_W-1:0] c,
                                      input logic [ADDR_W-1:0] k);
        inst_t w;
        w.rsvd     = '0;
        w.f.opcode = op;
        w.f.a      = a;
        w.f.b      = b;
        w.f.c      = c;
        w.f.cnst   = k;
        return w;
    endfunction

endpackage

// File: rtl/vpu_issue_if.sv
// vpu_issue_if: instruction-memory and execute-stage signals of the issue stage.
//   imem_en/imem_addr/imem_dout       - instruction BRAM read port
//   opcode/inst_addr_{a,b,c,const}    - decoded fields to the execute stage
//   start/vpu_done                    - issue pulse / completion pulse
// master: the issue stage; slave: BRAM + execute stage side.
interface vpu_issue_if
    import vpu_pkg::*;
#(
    parameter int PC_W = 10
);

    logic              imem_en;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_dout;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] inst_addr_a;
    logic [ADDR_W-1:0] inst_addr_b;
    logic [ADDR_W-1:0] inst_addr_c;
    logic [ADDR_W-1:0] inst_addr_const;
    logic              start;
    logic              vpu_done;

    modport master (
        output imem_en, imem_addr, opcode, inst_addr_a, inst_addr_b,
               inst_addr_c, inst_addr_const, start,
        input  imem_dout, vpu_done
    );

    modport slave (
        input  imem_en, imem_addr, opcode, inst_addr_a, inst_addr_b,
               inst_addr_c, inst_addr_const, start,
        output imem_dout, vpu_done
    );

endinterface

// File: rtl/vpu_issue_watchdog.sv
// vpu_issue_watchdog: down-counter that bounds the wait for the execute stage.
//   clk, rst_n - clock, async active-low reset
//   load_i     - high in the cycle before the wait begins (reloads the counter)
//   run_i      - high while waiting
//   expire_o   - high in the waiting cycle that hits terminal count
// Used only when VPU_ISSUE_WATCHDOG_EN is defined.
module vpu_issue_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    // Expiry in wait cycle TIMEOUT-1 lets the registered prog_done land
    // exactly TIMEOUT cycles after the start pulse.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TIMEOUT - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_INIT;
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/vpu_issue.sv
// vpu_issue: instruction fetch/issue stage in front of the VPU execute FSM.
// Fetches prog_len words from prog_base, decodes each, pulses start and holds
// the decoded fields until vpu_done. Stops early on an OPC_HALT word.
// Optional watchdog on the execute wait: define VPU_ISSUE_WATCHDOG_EN.
//   clk, rst_n    - clock, async active-low reset
//   run_i         - one-cycle program start (ignored while busy)
//   prog_base_i   - first instruction address
//   prog_len_i    - number of instructions (0 = immediate prog_done)
//   bus           - BRAM read port + execute-stage handshake (master)
//   busy_o        - program in progress
//   prog_done_o   - one-cycle end-of-program pulse
//   err_o         - sticky watchdog error (0 without the watchdog)
//   pc_o          - address of the current instruction
//
// state       | meaning
// ------------+------------------------------------------------
// ST_IDLE     | waiting for run
// ST_FETCH    | imem_en asserted with imem_addr = pc
// ST_WAIT_MEM | counting BRAM latency, capture word on last count
// ST_DECODE   | HALT check, register fields
// ST_ISSUE    | start pulse
// ST_WAIT_VPU | fields held, waiting for vpu_done
// ST_FINISH   | prog_done pulse
module vpu_issue
    import vpu_pkg::*;
#(
    parameter int PC_W     = 10,
    parameter int IMEM_LAT = 2,
    parameter int TIMEOUT  = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run_i,
    input  logic [PC_W-1:0] prog_base_i,
    input  logic [PC_W:0]   prog_len_i,
    vpu_issue_if.master     bus,
    output logic            busy_o,
    output logic            prog_done_o,
    output logic            err_o,
    output logic [PC_W-1:0] pc_o
);

    localparam int MC_W = 2;
    localparam logic [MC_W-1:0] MEM_CNT_INIT = MC_W'(IMEM_LAT - 1);
    localparam logic [PC_W:0]   REM_ONE      = (PC_W+1)'(1);

    if (IMEM_LAT < 1 || IMEM_LAT > 3 || TIMEOUT < 2) begin : g_bad_param
        $error("vpu_issue: IMEM_LAT must be 1..3 and TIMEOUT at least 2");
    end

    vpu_issue_state_t state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W:0]    rem_q, rem_d;
    logic [MC_W-1:0]  mem_cnt_q, mem_cnt_d;
    fields_t          word_q, word_d;
    fields_t          dec_q, dec_d;
    logic             imem_en_q, imem_en_d;
    logic [PC_W-1:0]  imem_addr_q, imem_addr_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             prog_done_q, prog_done_d;
    logic             done_now;
    logic             wd_expire;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rem_d     = rem_q;
        mem_cnt_d = mem_cnt_q;
        word_d    = word_q;
        dec_d     = dec_q;
        done_now  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    if (prog_len_i == '0) begin
                        done_now = 1'b1;
                    end else begin
                        pc_d    = prog_base_i;
                        rem_d   = prog_len_i;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                mem_cnt_d = MEM_CNT_INIT;
                state_d   = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                if (mem_cnt_q == '0) begin
                    word_d  = fields_t'(bus.imem_dout[FIELDS_W-1:0]);
                    state_d = ST_DECODE;
                end else begin
                    mem_cnt_d = mem_cnt_q - MC_W'(1);
                end
            end
            ST_DECODE: begin
                // HALT leaves the previously issued fields on the outputs.
                if (word_q.opcode == OPC_HALT) begin
                    state_d = ST_FINISH;
                end else begin
                    dec_d   = word_q;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // vpu_done in this cycle is ignored: we are not yet in WAIT_VPU.
                state_d = ST_WAIT_VPU;
            end
            ST_WAIT_VPU: begin
                if (bus.vpu_done) begin
                    rem_d   = rem_q - REM_ONE;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = (rem_q == REM_ONE) ? ST_FINISH : ST_FETCH;
                end else if (wd_expire) begin
                    done_now = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state demands,
        // so each pulse lines up with the cycle spent in its state.
        imem_en_d   = (state_d == ST_FETCH);
        imem_addr_d = (state_d == ST_FETCH) ? pc_d : imem_addr_q;
        start_d     = (state_d == ST_ISSUE);
        busy_d      = (state_d != ST_IDLE);
        prog_done_d = (state_d == ST_FINISH) || done_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            rem_q       <= '0;
            mem_cnt_q   <= '0;
            word_q      <= '0;
            dec_q       <= '0;
            imem_en_q   <= 1'b0;
            imem_addr_q <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            prog_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            rem_q       <= rem_d;
            mem_cnt_q   <= mem_cnt_d;
            word_q      <= word_d;
            dec_q       <= dec_d;
            imem_en_q   <= imem_en_d;
            imem_addr_q <= imem_addr_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            prog_done_q <= prog_done_d;
        end
    end

`ifdef VPU_ISSUE_WATCHDOG_EN
    logic err_q;

    vpu_issue_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (state_q == ST_ISSUE),
        .run_i    (state_q == ST_WAIT_VPU),
        .expire_o (wd_expire)
    );

    // Sticky until reset or the next run accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE && run_i) begin
            err_q <= 1'b0;
        end else if (state_q == ST_WAIT_VPU && !bus.vpu_done && wd_expire) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign wd_expire = 1'b0;
    assign err_o     = 1'b0;
`endif

    assign bus.imem_en         = imem_en_q;
    assign bus.imem_addr       = imem_addr_q;
    assign bus.opcode          = dec_q.opcode;
    assign bus.inst_addr_a     = dec_q.a;
    assign bus.inst_addr_b     = dec_q.b;
    assign bus.inst_addr_c     = dec_q.c;
    assign bus.inst_addr_const = dec_q.cnst;
    assign bus.start           = start_q;
    assign busy_o              = busy_q;
    assign prog_done_o         = prog_done_q;
    assign pc_o                = pc_q;

endmodule

// File: tb/tb_vpu_issue.sv
// Directed bench for vpu_issue: BRAM model with 2-cycle latency, execute
// stage answering vpu_done 8 cycles after each start (when enabled).
module tb_vpu_issue;
    import vpu_pkg::*;

    localparam int PC_W     = 10;
    localparam int IMEM_LAT = 2;
    localparam int TIMEOUT  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            run_i;
    logic [PC_W-1:0] prog_base_i;
    logic [PC_W:0]   prog_len_i;
    logic            busy_o, prog_done_o, err_o;
    logic [PC_W-1:0] pc_o;

    always #5 clk = ~clk;

    vpu_issue_if #(.PC_W(PC_W)) bus ();

    vpu_issue #(
        .PC_W     (PC_W),
        .IMEM_LAT (IMEM_LAT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run_i       (run_i),
        .prog_base_i (prog_base_i),
        .prog_len_i  (prog_len_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .prog_done_o (prog_done_o),
        .err_o       (err_o),
        .pc_o        (pc_o)
    );

    // Instruction BRAM: address sampled when imem_en, data out IMEM_LAT edges later.
    logic [63:0] mem [0:(1<<PC_W)-1];
    logic [63:0] pipe [IMEM_LAT];

    always @(posedge clk) begin
        if (bus.imem_en) pipe[0] <= mem[bus.imem_addr];
        for (int i = 1; i < IMEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.imem_dout = pipe[IMEM_LAT-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_en, n_start, n_pdone, stable_bad;
    int t_en_first, t_start_first, t_pdone;
    int done_cnt;
    bit auto_done;
    bit in_exec;
    logic [61:0] hold;
    logic [PC_W-1:0] addr_log [$];
    logic [61:0]     start_log [$];

    function automatic logic [63:0] mk(input logic [9:0] op, input logic [12:0] a,
                                       input logic [12:0] b, input logic [12:0] c,
                                       input logic [12:0] k, input logic [1:0] rs);
        return {rs, k, c, b, a, op};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        n_en = 0; n_start = 0; n_pdone = 0; stable_bad = 0;
        t_en_first = 0; t_start_first = 0; t_pdone = 0;
        done_cnt = 0; in_exec = 1'b0;
        addr_log.delete();
        start_log.delete();
    endtask

    // One cycle: observe at the falling edge, then drive the execute model.
    task automatic step();
        logic [61:0] cur;
        @(negedge clk);
        cyc++;
        cur = {bus.inst_addr_const, bus.inst_addr_c, bus.inst_addr_b,
               bus.inst_addr_a, bus.opcode};
        if (bus.imem_en) begin
            n_en++;
            addr_log.push_back(bus.imem_addr);
            if (n_en == 1) t_en_first = cyc;
        end
        if (bus.start) begin
            n_start++;
            start_log.push_back(cur);
            if (n_start == 1) t_start_first = cyc;
            hold = cur;
            in_exec = 1'b1;
            done_cnt = 9;
        end else if (in_exec && cur !== hold) begin
            stable_bad++;
        end
        if (prog_done_o) begin
            n_pdone++;
            t_pdone = cyc;
        end
        bus.vpu_done = 1'b0;
        if (auto_done && done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                bus.vpu_done = 1'b1;
                in_exec = 1'b0;
            end
        end
    endtask

    task automatic pulse_run(input logic [PC_W-1:0] base, input logic [PC_W:0] len);
        prog_base_i = base;
        prog_len_i  = len;
        run_i       = 1'b1;
        step();
        run_i       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        run_i = 1'b0;
        prog_base_i = '0;
        prog_len_i = '0;
        bus.vpu_done = 1'b0;
        auto_done = 1'b1;
        clear_logs();
        for (int i = 0; i < (1 << PC_W); i++) mem[i] = mk(10'h03C, 13'h1, 13'h2, 13'h3, 13'h4, 2'b00);
        mem[5]  = mk(10'h003, 13'h0010, 13'h0000, 13'h1FFF, 13'h0020, 2'b00);
        mem[6]  = mk(10'h3FF, 13'h1ABC, 13'h0001, 13'h0AAA, 13'h1555, 2'b11);
        mem[7]  = mk(10'h012, 13'h0123, 13'h0456, 13'h0789, 13'h0ABC, 2'b10);
        mem[20] = mk(10'h007, 13'h0001, 13'h0002, 13'h0003, 13'h0004, 2'b00);
        mem[21] = mk(10'h000, 13'h0111, 13'h0222, 13'h0333, 13'h0444, 2'b01);
        mem[22] = mk(10'h005, 13'h0AAA, 13'h0BBB, 13'h0CCC, 13'h0DDD, 2'b00);
        mem[23] = mk(10'h006, 13'h0EEE, 13'h0FFF, 13'h1000, 13'h1001, 2'b00);

        // Reset and idle.
        #23;
        chk("rst_busy", busy_o, 0);
        chk("rst_start", bus.start, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        for (int i = 0; i < 10; i++) step();
        chk("idle_busy", busy_o, 0);
        chk("idle_prog_done", prog_done_o, 0);
        chk("idle_start", bus.start, 0);
        chk("idle_pc", pc_o, 0);
        chk("idle_opcode", bus.opcode, 0);
        chk("idle_addr_c", bus.inst_addr_c, 0);
        chk("idle_err", err_o, 0);
        chk("idle_n_en", n_en, 0);

        // Three-instruction program from address 5.
        clear_logs();
        pulse_run(10'd5, 11'd3);
        chk("a_fetch_en", bus.imem_en, 1);
        chk("a_fetch_addr", bus.imem_addr, 5);
        chk("a_busy", busy_o, 1);
        for (int i = 0; i < 300; i++) begin
            if (n_pdone != 0) break;
            step();
        end
        chk("a_pdone_seen", n_pdone, 1);
        chk("a_busy_at_pdone", busy_o, 1);
        chk("a_n_start", n_start, 3);
        chk("a_n_fetch", addr_log.size(), 3);
        chk("a_addr0", addr_log[0], 5);
        chk("a_addr1", addr_log[1], 6);
        chk("a_addr2", addr_log[2], 7);
        chk("a_fetch_to_start", t_start_first - t_en_first, 4);
        chk("a_fields0", start_log[0], {13'h0020, 13'h1FFF, 13'h0000, 13'h0010, 10'h003});
        chk("a_fields1", start_log[1], {13'h1555, 13'h0AAA, 13'h0001, 13'h1ABC, 10'h3FF});
        chk("a_fields2", start_log[2], {13'h0ABC, 13'h0789, 13'h0456, 13'h0123, 10'h012});
        chk("a_stable", stable_bad, 0);
        step();
        chk("a_busy_after", busy_o, 0);
        chk("a_pdone_after", prog_done_o, 0);
        chk("a_pc_end", pc_o, 8);
        chk("a_fields_kept_op", bus.opcode, 10'h012);
        chk("a_fields_kept_k", bus.inst_addr_const, 13'h0ABC);
        chk("a_n_pdone_total", n_pdone, 1);

        // HALT at index 1 of a 4-word program; second run while busy is ignored.
        clear_logs();
        pulse_run(10'd20, 11'd4);
        for (int i = 0; i < 100; i++) begin
            if (n_start != 0) break;
            step();
        end
        step();
        pulse_run(10'd100, 11'd2);
        for (int i = 0; i < 300; i++) begin
            if (n_pdone != 0) break;
            step();
        end
        for (int i = 0; i < 5; i++) step();
        chk("h_n_start", n_start, 1);
        chk("h_n_pdone", n_pdone, 1);
        chk("h_pc", pc_o, 21);
        chk("h_n_fetch", addr_log.size(), 2);
        chk("h_addr1", addr_log[1], 21);
        chk("h_fields_kept", {bus.inst_addr_const, bus.inst_addr_c, bus.inst_addr_b,
                              bus.inst_addr_a, bus.opcode},
            {13'h0004, 13'h0003, 13'h0002, 13'h0001, 10'h007});
        chk("h_busy", busy_o, 0);

        // Zero-length program.
        clear_logs();
        pulse_run(10'd9, 11'd0);
        chk("z_pdone", prog_done_o, 1);
        chk("z_busy", busy_o, 0);
        step();
        chk("z_pdone_clr", prog_done_o, 0);
        for (int i = 0; i < 5; i++) step();
        chk("z_n_en", n_en, 0);
        chk("z_n_start", n_start, 0);
        chk("z_n_pdone", n_pdone, 1);
        chk("z_pc", pc_o, 21);

        // Reset while waiting for the execute stage.
        clear_logs();
        auto_done = 1'b0;
        pulse_run(10'd5, 11'd3);
        for (int i = 0; i < 100; i++) begin
            if (n_start != 0) break;
            step();
        end
        for (int i = 0; i < 10; i++) step();
        chk("r_busy_wait", busy_o, 1);
        chk("r_no_pdone", n_pdone, 0);
        chk("r_opcode_wait", bus.opcode, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("r_busy", busy_o, 0);
        chk("r_pc", pc_o, 0);
        chk("r_opcode", bus.opcode, 0);
        chk("r_addr_a", bus.inst_addr_a, 0);
        chk("r_start", bus.start, 0);
        step();
        rst_n = 1'b1;
        clear_logs();
        step();
        pulse_run(10'd6, 11'd1);
        chk("r2_fetch_en", bus.imem_en, 1);
        chk("r2_fetch_addr", bus.imem_addr, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("r2_en_async", bus.imem_en, 0);
        chk("r2_addr_async", bus.imem_addr, 0);
        step();
        rst_n = 1'b1;
        clear_logs();
        step();
        step();
        chk("r2_busy", busy_o, 0);

`ifdef VPU_ISSUE_WATCHDOG_EN
        // Execute stage never answers: watchdog ends the program.
        clear_logs();
        pulse_run(10'd5, 11'd2);
        for (int i = 0; i < 200; i++) begin
            if (n_pdone != 0) break;
            step();
        end
        chk("w_pdone_seen", n_pdone, 1);
        chk("w_latency", t_pdone - t_start_first, TIMEOUT);
        chk("w_err", err_o, 1);
        chk("w_busy", busy_o, 0);
        chk("w_n_start", n_start, 1);
        step();
        chk("w_err_sticky", err_o, 1);
        pulse_run(10'd5, 11'd0);
        chk("w_err_cleared", err_o, 0);
`else
        chk("err_tied", err_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
